// File: rtl/nic8_run_ctrl.sv
// Run/halt/single-step sequencer producing the nic8 core clock enable.
// Optional output-change watchpoint is compiled in with NIC8_OUT_WATCH_EN.
module nic8_run_ctrl #(
    parameter int CW          = 16,
    parameter bit RESUME_SKIP = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    pc,
    input  logic [7:0]    qreg,
    input  logic          cmd_run,
    input  logic          cmd_halt,
    input  logic          cmd_step,
    input  logic          bp_en,
    input  logic [7:0]    bp_addr,
    input  logic [CW-1:0] step_limit,
    output logic          cpu_en,
    output logic          running,
    output logic          halted,
    output logic [2:0]    halt_cause,
    output logic [CW-1:0] step_count
);

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    localparam logic [2:0] CAUSE_RESET = 3'd0;
    localparam logic [2:0] CAUSE_HALT  = 3'd1;
    localparam logic [2:0] CAUSE_STEP  = 3'd2;
    localparam logic [2:0] CAUSE_BP    = 3'd3;
    localparam logic [2:0] CAUSE_LIMIT = 3'd4;
    localparam logic [2:0] CAUSE_WATCH = 3'd5;

    state_t        state_q, state_d;
    logic [2:0]    cause_q, cause_d;
    logic          skip_q, skip_d;
    logic [CW-1:0] count_q, count_d;

    logic bp_hit;
    logic lim_hit;
    logic wp_hit;

    assign bp_hit  = bp_en && (pc == bp_addr) && !skip_q;
    assign lim_hit = (step_limit != '0) && (count_q >= step_limit);

`ifdef NIC8_OUT_WATCH_EN
    logic [7:0] q_prev_q;

    // Snapshot of qreg as of the last enabled edge; a difference means an OUT just retired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_prev_q <= 8'h00;
        end else if (cpu_en) begin
            q_prev_q <= qreg;
        end
    end

    assign wp_hit = !skip_q && (qreg != q_prev_q);
`else
    logic unused_qreg;

    assign unused_qreg = ^qreg;
    assign wp_hit      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HALTED;
            cause_q <= CAUSE_RESET;
            skip_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            skip_q  <= skip_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; in HALTED a cmd_halt masks step and run without changing the cause.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        skip_d  = skip_q;
        case (state_q)
            ST_HALTED: begin
                if (cmd_halt) begin
                    state_d = ST_HALTED;
                end else if (cmd_step) begin
                    state_d = ST_STEP;
                end else if (cmd_run) begin
                    state_d = ST_RUN;
                    skip_d  = RESUME_SKIP;
                end
            end
            ST_STEP: begin
                state_d = ST_HALTED;
                cause_d = CAUSE_STEP;
            end
            ST_RUN: begin
                skip_d = 1'b0;
                if (cmd_halt) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_HALT;
                end else if (bp_hit) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_BP;
                end else if (wp_hit) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_WATCH;
                end else if (lim_hit) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_LIMIT;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    // Output logic; cpu_en drops in the same cycle any RUN stop condition appears.
    always_comb begin
        cpu_en  = 1'b0;
        running = 1'b0;
        halted  = 1'b0;
        case (state_q)
            ST_STEP:   cpu_en = 1'b1;
            ST_RUN: begin
                running = 1'b1;
                cpu_en  = !cmd_halt && !bp_hit && !lim_hit && !wp_hit;
            end
            default:   halted = 1'b1;
        endcase
    end

    assign count_d    = (cpu_en && (count_q != '1)) ? count_q + 1'b1 : count_q;
    assign halt_cause = cause_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_nic8_run_ctrl.sv
// Directed self-checking bench for nic8_run_ctrl with a tiny core model that
// advances pc on every enabled edge.
module tb_nic8_run_ctrl;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    pc;
    logic [7:0]    qreg = 8'h00;
    logic          cmd_run = 1'b0;
    logic          cmd_halt = 1'b0;
    logic          cmd_step = 1'b0;
    logic          bp_en = 1'b0;
    logic [7:0]    bp_addr = 8'h00;
    logic [CW-1:0] step_limit = '0;
    logic          cpu_en;
    logic          running;
    logic          halted;
    logic [2:0]    halt_cause;
    logic [CW-1:0] step_count;

    int checks = 0;
    int errors = 0;
    int n_en;

    nic8_run_ctrl #(.CW(CW), .RESUME_SKIP(1'b1)) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .qreg(qreg),
        .cmd_run(cmd_run),
        .cmd_halt(cmd_halt),
        .cmd_step(cmd_step),
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .step_limit(step_limit),
        .cpu_en(cpu_en),
        .running(running),
        .halted(halted),
        .halt_cause(halt_cause),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    // Core model: pc advances on enabled edges only.
    always @(posedge clk or posedge reset) begin
        if (reset) pc <= 8'h00;
        else if (cpu_en) pc <= pc + 8'h01;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic pulse(input logic run, input logic hlt, input logic stp);
        cmd_run  = run;
        cmd_halt = hlt;
        cmd_step = stp;
        tick();
        cmd_run  = 1'b0;
        cmd_halt = 1'b0;
        cmd_step = 1'b0;
        #1;
    endtask

    // Counts enabled cycles until halted, bounded by a cycle budget.
    task automatic run_until_halt(input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget && !halted; i++) begin
            if (cpu_en) n++;
            tick();
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_halted", halted, 1);
        chk("rst_running", running, 0);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_count", step_count, 0);

        // Three single steps with gaps
        for (int s = 1; s <= 3; s++) begin
            pulse(1'b0, 1'b0, 1'b1);
            chk("step_en", cpu_en, 1);
            chk("step_not_halted", halted, 0);
            tick();
            chk("step_en_off", cpu_en, 0);
            chk("step_halted", halted, 1);
            chk("step_cause", halt_cause, 2);
            chk("step_count", step_count, s);
            tick();
            chk("step_gap_en", cpu_en, 0);
        end

        // Enabled-cycle budget of 10
        do_reset();
        step_limit = 16'd10;
        pulse(1'b1, 1'b0, 1'b0);
        run_until_halt(40, n_en);
        chk("lim_halted", halted, 1);
        chk("lim_en_cycles", n_en, 10);
        chk("lim_cause", halt_cause, 4);
        chk("lim_count", step_count, 10);
        pulse(1'b1, 1'b0, 1'b0);
        chk("lim_rerun_en", cpu_en, 0);
        run_until_halt(40, n_en);
        chk("lim_rerun_cycles", n_en, 0);
        chk("lim_rerun_cause", halt_cause, 4);
        // Step still honoured past the limit
        pulse(1'b0, 1'b0, 1'b1);
        chk("lim_step_en", cpu_en, 1);
        tick();
        chk("lim_step_count", step_count, 11);
        chk("lim_step_cause", halt_cause, 2);

        // Breakpoint at 0x05, then resume past it
        do_reset();
        step_limit = '0;
        bp_en = 1'b1;
        bp_addr = 8'h05;
        pulse(1'b1, 1'b0, 1'b0);
        run_until_halt(40, n_en);
        chk("bp_halted", halted, 1);
        chk("bp_pc", pc, 8'h05);
        chk("bp_cause", halt_cause, 3);
        chk("bp_count", step_count, 5);
        chk("bp_en_cycles", n_en, 5);
        pulse(1'b1, 1'b0, 1'b0);
        chk("bp_resume_en", cpu_en, 1);
        tick();
        chk("bp_resume_pc", pc, 8'h06);
        chk("bp_resume_running", running, 1);

        // cmd_halt while running: cpu_en drops the same cycle
        cmd_halt = 1'b1;
        #1;
        chk("halt_same_cycle_en", cpu_en, 0);
        tick();
        cmd_halt = 1'b0;
        #1;
        chk("halt_halted", halted, 1);
        chk("halt_cause", halt_cause, 1);
        chk("halt_pc", pc, 8'h06);
        chk("halt_count", step_count, 6);

        // halt + step together while HALTED: halt wins, nothing runs
        pulse(1'b0, 1'b1, 1'b1);
        chk("hs_en", cpu_en, 0);
        chk("hs_halted", halted, 1);
        tick();
        chk("hs_count", step_count, 6);
        chk("hs_cause", halt_cause, 1);

        // Reset mid-RUN at step_count 7
        do_reset();
        bp_en = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        repeat (7) tick();
        chk("mid_count_pre", step_count, 7);
        chk("mid_en_pre", cpu_en, 1);
        reset = 1'b1;
        #1;
        chk("mid_en", cpu_en, 0);
        chk("mid_count", step_count, 0);
        chk("mid_cause", halt_cause, 0);
        chk("mid_halted", halted, 1);
        tick();
        reset = 1'b0;
        #1;

        // Output watch: qreg changes while running
        qreg = 8'h00;
        pulse(1'b1, 1'b0, 1'b0);
        tick();
        qreg = 8'h2a;
        #1;
`ifdef NIC8_OUT_WATCH_EN
        chk("wp_en", cpu_en, 0);
        tick();
        chk("wp_halted", halted, 1);
        chk("wp_cause", halt_cause, 5);
`else
        chk("wp_en", cpu_en, 1);
        tick();
        chk("wp_running", running, 1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("wp_cause", halt_cause, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nic8_run_ctrl.md
Name: nic8_run_ctrl

Overview:
- Run/halt/single-step sequencer for the nic8 datapath; drives the clock-enable that gates every architectural register update (pc, ir, areg, breg, xreg, qreg).
- Sits between the bench or debug front-end and the CPU core.
- Provides a PC breakpoint, an enabled-cycle budget (hardware equivalent of the +steps limit), an enabled-cycle counter and a halt-cause code.

Parameters:
CW, 16, width of step counter and step limit
RESUME_SKIP, 1, 1 = breakpoint ignored on the first enabled cycle after leaving HALTED via cmd_run

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; all state cleared immediately
pc  in  8  current program counter from core
qreg  in  8  output register value from core
cmd_run  in  1  one-cycle pulse: start free running
cmd_halt  in  1  one-cycle pulse: stop
cmd_step  in  1  one-cycle pulse: execute exactly one enabled cycle
bp_en  in  1  breakpoint enable
bp_addr  in  8  breakpoint PC
step_limit  in  CW  enabled-cycle budget; 0 = unlimited
cpu_en  out  1  clock enable to core; core updates only on clk rising edges where cpu_en=1
running  out  1  state==RUN
halted  out  1  state==HALTED
halt_cause  out  3  0 reset, 1 cmd_halt, 2 step done, 3 breakpoint, 4 limit, 5 output change
step_count  out  CW  number of enabled cycles since reset, saturating at all-ones

Behaviour:
- Reset values (asynchronous): state=HALTED, cpu_en=0, running=0, halted=1, halt_cause=0, step_count=0, skip flag=0.
- States: HALTED, RUN, STEP. Encoding is free; only the outputs above are observable.
- Command priority when pulses coincide: cmd_halt > cmd_step > cmd_run. Commands are ignored in states that do not list them.
- HALTED:
  - cmd_step -> STEP.
  - cmd_run -> RUN; skip flag set if RESUME_SKIP=1.
- STEP:
  - cpu_en=1 for exactly this one cycle.
  - Next state HALTED, halt_cause=2.
  - Any command arriving in STEP is ignored.
- RUN:
  - cmd_halt -> HALTED, cause 1. cpu_en=0 in the same cycle (combinational); no further core update.
  - bp_hit = bp_en & (pc==bp_addr) & !skip. On bp_hit, cpu_en=0 in the same cycle -> HALTED, cause 3. The instruction at bp_addr is not executed.
  - lim_hit = (step_limit!=0) & (step_count>=step_limit). On lim_hit, cpu_en=0 -> HALTED, cause 4.
  - Same-cycle priority: halt(1) > breakpoint(3) > output change(5) > limit(4).
  - skip clears after the first cycle in RUN.
- cpu_en = (state==STEP) | (state==RUN & !cmd_halt & !bp_hit & !lim_hit & !wp_hit). It is the only combinational output.
- step_count increments by 1 on every rising edge with cpu_en=1 and holds at 2^CW-1.
- Changing step_limit mid-run takes effect in the next comparison. A limit already at or below step_count halts on the next RUN cycle.
- cmd_step is honoured even when step_count>=step_limit; the limit gates RUN only.
- halt_cause holds until the next halting event or reset.
- Reset asserted mid-RUN/STEP: cpu_en drops at once; state returns to HALTED with cause 0.

Optional Feature:
- Macro: NIC8_OUT_WATCH_EN.
- Defined:
  - Internal 8-bit q_prev is loaded with qreg on every cpu_en edge.
  - In RUN with skip=0, wp_hit = (qreg != q_prev). It forces cpu_en=0 and moves to HALTED with cause 5, so the core stops one cycle after an OUT.
- Undefined:
  - wp_hit is 0; qreg port is present but ignored; cause 5 is never produced.

Test Plan:
- Reset, then cmd_step x3 with gaps -> exactly 3 single-cycle cpu_en pulses; step_count=3; halt_cause=2; halted=1 between pulses.
- step_limit=10, cmd_run -> cpu_en high exactly 10 cycles; halted, cause 4, step_count=10. A further cmd_run produces 0 enabled cycles.
- bp_en=1, bp_addr=0x05, core pc increments from 0, cmd_run -> halt with pc=0x05 and cause 3; step_count=5. cmd_run resumes past 0x05 (RESUME_SKIP=1).
- cmd_halt and cmd_step in the same cycle while HALTED -> no cpu_en. cmd_halt during RUN -> cpu_en low that same cycle; cause 1.
- Reset asserted mid-RUN at step_count=7 -> cpu_en=0 immediately; step_count=0, cause 0, halted=1.
- NIC8_OUT_WATCH_EN defined, qreg changes 0x00->0x2a while running -> halted next cycle, cause 5. Undefined -> continues running.
